// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back stage and the architectural
// register file.
package wb_regfile_pkg;

    localparam int RWIDTH = 5;
    localparam int WORD   = 32;
    localparam int NREGS  = 32;

    typedef logic [RWIDTH-1:0] reg_idx_t;
    typedef logic [WORD-1:0]   word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_select.sv
// MemtoReg write-back select: picks load data or the ALU result.
// Shared with the EX-stage forwarding path so that both agree on the value.
module wb_select
    import wb_regfile_pkg::*;
(
    input  logic  memtoreg_i,
    input  word_t mem_data_i,
    input  word_t alu_result_i,
    output word_t write_data_o
);

    // Zero-delay 2:1 select between memory read data and ALU result.
    always_comb begin
        write_data_o = alu_result_i;
        if (memtoreg_i) begin
            write_data_o = mem_data_i;
        end else begin
            write_data_o = alu_result_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Architectural 32x32 register file fed by the MEM/WB stage. Provides the
// write-back value for forwarding and two decode read ports that see a
// same-cycle write through a bypass.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              WB_RegWrite,
    input  logic              WB_MemtoReg,
    input  logic [WORD-1:0]   WB_Data_memory_Read_data,
    input  logic [WORD-1:0]   WB_ALU_result,
    input  logic [RWIDTH-1:0] WB_MUX8_out,
    input  logic [RWIDTH-1:0] ID_rs,
    input  logic [RWIDTH-1:0] ID_rt,
    output logic [WORD-1:0]   ID_Read_data1,
    output logic [WORD-1:0]   ID_Read_data2,
    output logic [WORD-1:0]   WB_Write_data,
    output logic              WB_Write_valid
);

    word_t wdata_s;
    logic  valid_s;
    word_t regs_q [NREGS];

    wb_select u_wb_select (
        .memtoreg_i   (WB_MemtoReg),
        .mem_data_i   (WB_Data_memory_Read_data),
        .alu_result_i (WB_ALU_result),
        .write_data_o (wdata_s)
    );

    // A write is live only out of reset and for a non-zero destination;
    // this also keeps an X on MemtoReg harmless when RegWrite is low.
    always_comb begin
        valid_s = 1'b0;
        if (Reset_n && WB_RegWrite && (WB_MUX8_out != REG_ZERO)) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
    end

    // Array update: reset clears everything and wins over a concurrent write.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {WORD{1'b0}};
            end
        end else if (valid_s) begin
            regs_q[WB_MUX8_out] <= wdata_s;
        end
    end

    // Read port A: $zero, then same-cycle bypass, then the array.
    always_comb begin
        ID_Read_data1 = {WORD{1'b0}};
        if (ID_rs == REG_ZERO) begin
            ID_Read_data1 = {WORD{1'b0}};
        end else if (valid_s && (ID_rs == WB_MUX8_out)) begin
            ID_Read_data1 = wdata_s;
        end else begin
            ID_Read_data1 = regs_q[ID_rs];
        end
    end

    // Read port B: identical priority to port A, indexed by rt.
    always_comb begin
        ID_Read_data2 = {WORD{1'b0}};
        if (ID_rt == REG_ZERO) begin
            ID_Read_data2 = {WORD{1'b0}};
        end else if (valid_s && (ID_rt == WB_MUX8_out)) begin
            ID_Read_data2 = wdata_s;
        end else begin
            ID_Read_data2 = regs_q[ID_rt];
        end
    end

    assign WB_Write_data  = wdata_s;
    assign WB_Write_valid = valid_s;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a behavioural register-file model and
// a per-cycle comparison of every output against it.
module tb_wb_regfile;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        WB_RegWrite;
    logic        WB_MemtoReg;
    logic [31:0] WB_Data_memory_Read_data;
    logic [31:0] WB_ALU_result;
    logic [4:0]  WB_MUX8_out;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic [31:0] ID_Read_data1;
    logic [31:0] ID_Read_data2;
    logic [31:0] WB_Write_data;
    logic        WB_Write_valid;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    logic [31:0] model_regs [32];

    wb_regfile dut (
        .Clock                    (Clock),
        .Reset_n                  (Reset_n),
        .WB_RegWrite              (WB_RegWrite),
        .WB_MemtoReg              (WB_MemtoReg),
        .WB_Data_memory_Read_data (WB_Data_memory_Read_data),
        .WB_ALU_result            (WB_ALU_result),
        .WB_MUX8_out              (WB_MUX8_out),
        .ID_rs                    (ID_rs),
        .ID_rt                    (ID_rt),
        .ID_Read_data1            (ID_Read_data1),
        .ID_Read_data2            (ID_Read_data2),
        .WB_Write_data            (WB_Write_data),
        .WB_Write_valid           (WB_Write_valid)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, required %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: value the write-back stage is presenting this cycle.
    function automatic logic [31:0] m_wdata();
        if (WB_MemtoReg == 1'b1) return WB_Data_memory_Read_data;
        return WB_ALU_result;
    endfunction

    function automatic bit m_valid();
        return (Reset_n === 1'b1) && (WB_RegWrite === 1'b1) && (WB_MUX8_out != 5'd0);
    endfunction

    // Model: what a decode read of register idx must return right now.
    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (m_valid() && idx == WB_MUX8_out) return m_wdata();
        return model_regs[idx];
    endfunction

    // Model state update at each rising edge.
    always @(posedge Clock) begin
        if (Reset_n === 1'b0) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        end else if (m_valid()) begin
            model_regs[WB_MUX8_out] = m_wdata();
        end
    end

    // Every-cycle comparison of all outputs, away from the active edge.
    always @(negedge Clock) begin
        if (checking) begin
            check("cyc_rd1",   ID_Read_data1, m_read(ID_rs));
            check("cyc_rd2",   ID_Read_data2, m_read(ID_rt));
            check("cyc_wdata", WB_Write_data, m_wdata());
            check("cyc_valid", {31'h0, WB_Write_valid}, {31'h0, m_valid()});
        end
    end

    task automatic edge_then_drive();
        @(posedge Clock);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        Reset_n = 1'b0; WB_RegWrite = 1'b0; WB_MemtoReg = 1'b0;
        WB_Data_memory_Read_data = 32'h0; WB_ALU_result = 32'h0;
        WB_MUX8_out = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0;
        edge_then_drive();
        Reset_n = 1'b1;
        checking = 1'b1;

        // Preload reg[5], then reset clears it.
        WB_RegWrite = 1'b1; WB_ALU_result = 32'hDEADBEEF; WB_MUX8_out = 5'd5; ID_rs = 5'd5;
        #2 check("preload_bypass", ID_Read_data1, 32'hDEADBEEF);
        edge_then_drive();
        WB_RegWrite = 1'b0;
        #2 check("preload_array", ID_Read_data1, 32'hDEADBEEF);
        Reset_n = 1'b0;
        #1 check("reset_valid_low", {31'h0, WB_Write_valid}, 32'h0);
        edge_then_drive();
        Reset_n = 1'b1;
        #2 check("reset_clears_r5", ID_Read_data1, 32'h0);

        // ALU write, read next cycle on port B.
        WB_RegWrite = 1'b1; WB_MemtoReg = 1'b0; WB_ALU_result = 32'h12345678;
        WB_MUX8_out = 5'd9; ID_rt = 5'd9;
        edge_then_drive();
        WB_RegWrite = 1'b0; WB_ALU_result = 32'h0;
        #2 check("alu_write_r9", ID_Read_data2, 32'h12345678);

        // X on MemtoReg with RegWrite low must leave the array alone.
        WB_MemtoReg = 1'bx;
        edge_then_drive();
        WB_MemtoReg = 1'b0;
        #2 check("x_safe_r9", ID_Read_data2, 32'h12345678);

        // Load write with same-cycle bypass on both ports.
        WB_RegWrite = 1'b1; WB_MemtoReg = 1'b1; WB_Data_memory_Read_data = 32'hCAFEF00D;
        WB_ALU_result = 32'h1; WB_MUX8_out = 5'd17; ID_rs = 5'd17; ID_rt = 5'd17;
        #2;
        check("load_byp_rd1", ID_Read_data1, 32'hCAFEF00D);
        check("load_byp_rd2", ID_Read_data2, 32'hCAFEF00D);
        check("load_wdata",   WB_Write_data, 32'hCAFEF00D);
        check("load_valid",   {31'h0, WB_Write_valid}, 32'h1);
        edge_then_drive();
        WB_RegWrite = 1'b0; WB_MemtoReg = 1'b0;
        #2;
        check("load_arr_rd1", ID_Read_data1, 32'hCAFEF00D);
        check("load_arr_rd2", ID_Read_data2, 32'hCAFEF00D);
        check("wdata_alu_sel", WB_Write_data, 32'h1);

        // $zero protection.
        WB_RegWrite = 1'b1; WB_ALU_result = 32'hFFFFFFFF; WB_MUX8_out = 5'd0; ID_rs = 5'd0;
        #2;
        check("zero_valid", {31'h0, WB_Write_valid}, 32'h0);
        check("zero_rd_same", ID_Read_data1, 32'h0);
        check("zero_wdata", WB_Write_data, 32'hFFFFFFFF);
        edge_then_drive();
        WB_RegWrite = 1'b0;
        #2 check("zero_rd_next", ID_Read_data1, 32'h0);

        // Reset versus write collision on reg[3] (preloaded non-zero first).
        WB_RegWrite = 1'b1; WB_ALU_result = 32'h00000011; WB_MUX8_out = 5'd3; ID_rs = 5'd3;
        edge_then_drive();
        Reset_n = 1'b0; WB_ALU_result = 32'hAAAA5555;
        #2;
        check("coll_valid", {31'h0, WB_Write_valid}, 32'h0);
        check("coll_rd_array", ID_Read_data1, 32'h00000011);
        edge_then_drive();
        Reset_n = 1'b1; WB_RegWrite = 1'b0;
        #2 check("coll_r3_zero", ID_Read_data1, 32'h0);

        // Disabled write leaves reg[4] unchanged.
        WB_RegWrite = 1'b0; WB_MUX8_out = 5'd4; WB_ALU_result = 32'h77; ID_rs = 5'd4;
        #2 check("dis_before", ID_Read_data1, 32'h0);
        edge_then_drive();
        #2 check("dis_after", ID_Read_data1, 32'h0);

        // Back-to-back writes to every register, alternating sources, while
        // reading the one being written and the previous one.
        for (int i = 1; i < 32; i++) begin
            WB_RegWrite = 1'b1;
            WB_MemtoReg = i[0];
            WB_Data_memory_Read_data = 32'h01010101 * i;
            WB_ALU_result = 32'hF0000000 | i;
            WB_MUX8_out = i[4:0];
            ID_rs = i[4:0];
            ID_rt = i[4:0] - 5'd1;
            edge_then_drive();
        end
        WB_RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ID_rs = i[4:0];
            ID_rt = 5'd31 - i[4:0];
            edge_then_drive();
        end
        ID_rs = 5'd6; ID_rt = 5'd7;
        #2;
        check("sweep_r6_alu", ID_Read_data1, 32'hF0000006);
        check("sweep_r7_mem", ID_Read_data2, 32'h07070707);

        edge_then_drive();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
